// File: rtl/mem_sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter (mem_sram_arbiter).
// Build option: define MEM_SRAM_ARB_RR_EN for round-robin arbitration.
// It is off by default, which gives fixed priority with dmem over imem.
package mem_sram_arb_pkg;

    // Port indices. They are also the encoding of the round-robin "last granted" pointer.
    localparam logic ARB_PORT_IMEM = 1'b0;
    localparam logic ARB_PORT_DMEM = 1'b1;

    // Returns true when a port wins a two-way contention, given the last-granted port.
    function automatic logic arb_rr_wins(input logic port, input logic last_gnt);
        return (port != last_gnt);
    endfunction

endpackage

// File: rtl/mem_sram_arb_rsp.sv
// Response tracker for one arbiter port: in-flight flag, stall hold register,
// rvalid/rdata muxing and the "blocked" indication used by arbitration.
module mem_sram_arb_rsp
    import mem_sram_arb_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_gnt,
    input  logic             i_rready,
    input  logic [WIDTH-1:0] i_sram_rdata,
    output logic             o_rvalid,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_blocked
);

    logic             r_inflight;
    logic             r_held;
    logic [WIDTH-1:0] r_hold_data;

    // The SRAM answers exactly one cycle after a grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= i_gnt;
        end
    end

    // Capture a stalled SRAM response. SRAM reads done for the other port cannot overwrite it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_held      <= 1'b0;
            r_hold_data <= '0;
        end else if (r_inflight && !i_rready) begin
            r_held      <= 1'b1;
            r_hold_data <= i_sram_rdata;
        end else if (r_held && i_rready) begin
            r_held      <= 1'b0;
        end
    end

    assign o_rvalid  = r_inflight | r_held;
    assign o_rdata   = r_held ? r_hold_data : i_sram_rdata;
    assign o_blocked = o_rvalid & ~i_rready;

endmodule

// File: rtl/mem_sram_arbiter.sv
// Two-requester arbiter and sequencer for a single-ported SRAM with a one-cycle read latency.
// Build option: MEM_SRAM_ARB_RR_EN selects round-robin arbitration. By default it is
// undefined and dmem has fixed priority over imem.
//
// Handshakes:
//  - req/gnt: the requester holds req, addr, strb and wdata stable until gnt. gnt is
//    combinational and means the SRAM access happens in this cycle.
//  - rvalid/rready: the response is transferred in a cycle where both are high. While
//    rvalid && !rready the port is blocked and is not granted. When rready accepts the
//    response, the same port may be granted again in that same cycle, so a combinational
//    path runs from rready to gnt.
module mem_sram_arbiter
    import mem_sram_arb_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH),
    localparam int SW    = WIDTH / 8
) (
    input  logic             g_clk,
    input  logic             g_reset,
    input  logic             imem_req,
    output logic             imem_gnt,
    input  logic [AW-1:0]    imem_addr,
    output logic             imem_rvalid,
    input  logic             imem_rready,
    output logic [WIDTH-1:0] imem_rdata,
    input  logic             dmem_req,
    output logic             dmem_gnt,
    input  logic [AW-1:0]    dmem_addr,
    input  logic [SW-1:0]    dmem_strb,
    input  logic [WIDTH-1:0] dmem_wdata,
    output logic             dmem_rvalid,
    input  logic             dmem_rready,
    output logic [WIDTH-1:0] dmem_rdata,
    output logic             sram_cen,
    output logic [SW-1:0]    sram_wstrb,
    output logic [AW-1:0]    sram_addr,
    output logic [WIDTH-1:0] sram_wdata,
    input  logic [WIDTH-1:0] sram_rdata
);

    logic             w_imem_blocked;
    logic             w_dmem_blocked;
    logic             w_imem_elig;
    logic             w_dmem_elig;
    logic             w_dmem_wins;
    logic             w_imem_gnt;
    logic             w_dmem_gnt;
    logic [AW-1:0]    r_addr_last;
    logic [WIDTH-1:0] r_wdata_last;

    assign w_imem_elig = imem_req & ~w_imem_blocked;
    assign w_dmem_elig = dmem_req & ~w_dmem_blocked;

`ifdef MEM_SRAM_ARB_RR_EN
    logic r_last_gnt;

    // Remember the last-granted port. Reset points at imem so that dmem wins the first contention.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_last_gnt <= ARB_PORT_IMEM;
        end else if (w_dmem_gnt) begin
            r_last_gnt <= ARB_PORT_DMEM;
        end else if (w_imem_gnt) begin
            r_last_gnt <= ARB_PORT_IMEM;
        end
    end

    assign w_dmem_wins = arb_rr_wins(ARB_PORT_DMEM, r_last_gnt);
`else
    assign w_dmem_wins = 1'b1;
`endif

    // Pick at most one eligible port. Nothing is granted while reset is asserted.
    always_comb begin
        w_imem_gnt = 1'b0;
        w_dmem_gnt = 1'b0;
        if (!g_reset) begin
            if (w_imem_elig && w_dmem_elig) begin
                w_dmem_gnt = w_dmem_wins;
                w_imem_gnt = ~w_dmem_wins;
            end else begin
                w_imem_gnt = w_imem_elig;
                w_dmem_gnt = w_dmem_elig;
            end
        end
    end

    assign imem_gnt = w_imem_gnt;
    assign dmem_gnt = w_dmem_gnt;
    assign sram_cen = w_imem_gnt | w_dmem_gnt;

    // Keep the last address and write data so that idle cycles do not toggle the SRAM bus.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_addr_last  <= '0;
            r_wdata_last <= '0;
        end else if (w_dmem_gnt) begin
            r_addr_last  <= dmem_addr;
            r_wdata_last <= dmem_wdata;
        end else if (w_imem_gnt) begin
            r_addr_last  <= imem_addr;
        end
    end

    // Route the granted port onto the SRAM. imem never writes.
    always_comb begin
        sram_addr  = r_addr_last;
        sram_wdata = r_wdata_last;
        sram_wstrb = '0;
        if (w_dmem_gnt) begin
            sram_addr  = dmem_addr;
            sram_wdata = dmem_wdata;
            sram_wstrb = dmem_strb;
        end else if (w_imem_gnt) begin
            sram_addr  = imem_addr;
        end
    end

    mem_sram_arb_rsp #(.WIDTH(WIDTH)) u_imem_rsp (
        .i_clk        (g_clk),
        .i_rst        (g_reset),
        .i_gnt        (w_imem_gnt),
        .i_rready     (imem_rready),
        .i_sram_rdata (sram_rdata),
        .o_rvalid     (imem_rvalid),
        .o_rdata      (imem_rdata),
        .o_blocked    (w_imem_blocked)
    );

    mem_sram_arb_rsp #(.WIDTH(WIDTH)) u_dmem_rsp (
        .i_clk        (g_clk),
        .i_rst        (g_reset),
        .i_gnt        (w_dmem_gnt),
        .i_rready     (dmem_rready),
        .i_sram_rdata (sram_rdata),
        .o_rvalid     (dmem_rvalid),
        .o_rdata      (dmem_rdata),
        .o_blocked    (w_dmem_blocked)
    );

endmodule

// File: tb/tb_mem_sram_arbiter.sv
// Self-checking bench for mem_sram_arbiter. It holds a behavioural SRAM, a shadow memory
// and per-port expected-response queues. Grants follow from the port rules: a port is
// blocked while it has an unaccepted response and rready is low. In the default build
// dmem wins a contention. With MEM_SRAM_ARB_RR_EN defined, the port not granted last wins.
module tb_mem_sram_arbiter;

    localparam int WIDTH = 64;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int SW    = WIDTH / 8;
    localparam logic [WIDTH-1:0] WORD_10 = 64'h0123_4567_89AB_CDEF;
    localparam logic [WIDTH-1:0] WORD_20 = 64'hDEAD_BEEF_CAFE_F00D;

    logic             g_clk;
    logic             g_reset;
    logic             imem_req, imem_gnt, imem_rvalid, imem_rready;
    logic [AW-1:0]    imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             dmem_req, dmem_gnt, dmem_rvalid, dmem_rready;
    logic [AW-1:0]    dmem_addr;
    logic [SW-1:0]    dmem_strb;
    logic [WIDTH-1:0] dmem_wdata, dmem_rdata;
    logic             sram_cen;
    logic [SW-1:0]    sram_wstrb;
    logic [AW-1:0]    sram_addr;
    logic [WIDTH-1:0] sram_wdata, sram_rdata;

    // ---------------- clock / reset ----------------
    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    mem_sram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .imem_req    (imem_req),
        .imem_gnt    (imem_gnt),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rready (imem_rready),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_gnt    (dmem_gnt),
        .dmem_addr   (dmem_addr),
        .dmem_strb   (dmem_strb),
        .dmem_wdata  (dmem_wdata),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rready (dmem_rready),
        .dmem_rdata  (dmem_rdata),
        .sram_cen    (sram_cen),
        .sram_wstrb  (sram_wstrb),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    // Behavioural single-port SRAM: one-cycle read latency, byte-strobed writes.
    logic [WIDTH-1:0] sram_mem [DEPTH];
    always @(posedge g_clk) begin
        if (sram_cen) begin
            sram_rdata <= sram_mem[sram_addr];
            for (int b = 0; b < SW; b++)
                if (sram_wstrb[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [WIDTH-1:0] shadow [DEPTH];
    logic [WIDTH-1:0] imem_exp_q[$];
    logic [WIDTH-1:0] dmem_exp_q[$];
    logic             dmem_wr_q[$];
    logic             mdl_last_dmem;
    logic             exp_igrant, exp_dgrant;
    int               n_checks, n_pass;

    task automatic model_clear();
        imem_exp_q.delete();
        dmem_exp_q.delete();
        dmem_wr_q.delete();
        mdl_last_dmem = 1'b0;
    endtask

    task automatic model_predict();
        logic ie, de;
        ie = imem_req && !((imem_exp_q.size() != 0) && !imem_rready);
        de = dmem_req && !((dmem_exp_q.size() != 0) && !dmem_rready);
        exp_igrant = 1'b0;
        exp_dgrant = 1'b0;
        if (g_reset) begin
            exp_igrant = 1'b0;
        end else if (ie && de) begin
`ifdef MEM_SRAM_ARB_RR_EN
            if (mdl_last_dmem) exp_igrant = 1'b1;
            else exp_dgrant = 1'b1;
`else
            exp_dgrant = 1'b1;
`endif
        end else begin
            exp_igrant = ie;
            exp_dgrant = de;
        end
    endtask

    task automatic model_commit();
        if (imem_exp_q.size() != 0 && imem_rready) imem_exp_q.delete(0);
        if (dmem_exp_q.size() != 0 && dmem_rready) begin
            dmem_exp_q.delete(0);
            dmem_wr_q.delete(0);
        end
        if (exp_igrant) begin
            imem_exp_q.push_back(shadow[imem_addr]);
            mdl_last_dmem = 1'b0;
        end
        if (exp_dgrant) begin
            dmem_exp_q.push_back(shadow[dmem_addr]);
            dmem_wr_q.push_back(dmem_strb != '0);
            for (int b = 0; b < SW; b++)
                if (dmem_strb[b]) shadow[dmem_addr][8*b +: 8] = dmem_wdata[8*b +: 8];
            mdl_last_dmem = 1'b1;
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge. Outputs are sampled at the falling edge.
    task automatic settle();
        @(negedge g_clk);
        model_predict();
    endtask

    task automatic advance();
        model_commit();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req = 1'b0; imem_addr = '0; imem_rready = 1'b1;
        dmem_req = 1'b0; dmem_addr = '0; dmem_strb = '0; dmem_wdata = '0; dmem_rready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        g_reset = 1'b1;
        idle_inputs();
        imem_req = 1'b1;
        dmem_req = 1'b1;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        n_checks++; if (imem_gnt !== 1'b0) $display("FAIL reset_imem_gnt: got %b expected 0", imem_gnt); else n_pass++;
        n_checks++; if (dmem_gnt !== 1'b0) $display("FAIL reset_dmem_gnt: got %b expected 0", dmem_gnt); else n_pass++;
        n_checks++; if (sram_cen !== 1'b0) $display("FAIL reset_cen: got %b expected 0", sram_cen); else n_pass++;
        n_checks++; if (sram_wstrb !== '0) $display("FAIL reset_wstrb: got %h expected 0", sram_wstrb); else n_pass++;
        n_checks++; if ({imem_rvalid, dmem_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", {imem_rvalid, dmem_rvalid}); else n_pass++;
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        idle_inputs();
        model_clear();
        settle();
        n_checks++; if ({imem_rvalid, dmem_rvalid} !== 2'b00) $display("FAIL post_reset_rvalid: got %b expected 00", {imem_rvalid, dmem_rvalid}); else n_pass++;
        advance();
    endtask

    task automatic preload();
        int grants;
        logic [WIDTH-1:0] w;
        grants = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w = {$urandom, $urandom};
            dmem_req = 1'b1; dmem_addr = AW'(i); dmem_strb = '1;
            dmem_wdata = (i == 16) ? WORD_10 : w;
            settle();
            if (dmem_gnt === 1'b1) grants++;
            advance();
        end
        idle_inputs();
        settle();
        advance();
        n_checks++; if (grants != DEPTH) $display("FAIL preload_grants: got %0d expected %0d", grants, DEPTH); else n_pass++;
    endtask

    task automatic test_single_read();
        imem_req = 1'b1; imem_addr = AW'(16); imem_rready = 1'b1;
        settle();
        n_checks++; if (imem_gnt !== 1'b1) $display("FAIL single_gnt: got %b expected 1", imem_gnt); else n_pass++;
        n_checks++; if (sram_addr !== AW'(16) || sram_wstrb !== '0) $display("FAIL single_sram: got addr %h strb %h expected addr 10 strb 0", sram_addr, sram_wstrb); else n_pass++;
        advance();
        imem_req = 1'b0;
        settle();
        n_checks++; if (imem_rvalid !== 1'b1) $display("FAIL single_rvalid: got %b expected 1", imem_rvalid); else n_pass++;
        n_checks++; if (imem_rdata !== WORD_10) $display("FAIL single_rdata: got %h expected %h", imem_rdata, WORD_10); else n_pass++;
        advance();
    endtask

    task automatic test_contention();
        logic prev_d;
        imem_req = 1'b1; imem_addr = AW'(33);
        dmem_req = 1'b1; dmem_addr = AW'(32); dmem_strb = 8'hFF; dmem_wdata = WORD_20;
        settle();
        n_checks++; if ({imem_gnt, dmem_gnt} !== {exp_igrant, exp_dgrant}) $display("FAIL cont_first: got %b expected %b", {imem_gnt, dmem_gnt}, {exp_igrant, exp_dgrant}); else n_pass++;
`ifndef MEM_SRAM_ARB_RR_EN
        n_checks++; if ({dmem_gnt, sram_wstrb, sram_wdata} !== {1'b1, 8'hFF, WORD_20}) $display("FAIL cont_dmem_first: got gnt %b strb %h wdata %h", dmem_gnt, sram_wstrb, sram_wdata); else n_pass++;
`endif
        advance();
        if (exp_dgrant) dmem_req = 1'b0; else imem_req = 1'b0;
        settle();
        n_checks++; if ((imem_gnt | dmem_gnt) !== 1'b1 || {imem_gnt, dmem_gnt} !== {exp_igrant, exp_dgrant}) $display("FAIL cont_second: got %b expected %b", {imem_gnt, dmem_gnt}, {exp_igrant, exp_dgrant}); else n_pass++;
        advance();
        idle_inputs();
        dmem_req = 1'b1; dmem_addr = AW'(32);
        settle();
        advance();
        dmem_req = 1'b0;
        settle();
        n_checks++; if (dmem_rdata !== WORD_20) $display("FAIL cont_readback: got %h expected %h", dmem_rdata, WORD_20); else n_pass++;
        advance();
        // Repeated contention: fixed priority always picks dmem, round-robin alternates.
        prev_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            imem_req = 1'b1; imem_addr = AW'(k);
            dmem_req = 1'b1; dmem_addr = AW'(k + 8);
            settle();
            n_checks++; if ({imem_gnt, dmem_gnt} !== {exp_igrant, exp_dgrant}) $display("FAIL cont_repeat%0d: got %b expected %b", k, {imem_gnt, dmem_gnt}, {exp_igrant, exp_dgrant}); else n_pass++;
`ifdef MEM_SRAM_ARB_RR_EN
            if (k > 0) begin
                n_checks++; if (dmem_gnt === prev_d) $display("FAIL cont_alternate%0d: got dmem_gnt %b expected %b", k, dmem_gnt, !prev_d); else n_pass++;
            end
`else
            n_checks++; if (dmem_gnt !== 1'b1) $display("FAIL cont_fixed%0d: got dmem_gnt %b expected 1", k, dmem_gnt); else n_pass++;
`endif
            prev_d = dmem_gnt;
            advance();
        end
        idle_inputs();
        settle();
        advance();
    endtask

    task automatic test_stall();
        dmem_req = 1'b1; dmem_addr = AW'(16); dmem_rready = 1'b0;
        settle();
        n_checks++; if (dmem_gnt !== 1'b1) $display("FAIL stall_first_gnt: got %b expected 1", dmem_gnt); else n_pass++;
        advance();
        dmem_addr = AW'(32);
        for (int k = 0; k < 5; k++) begin
            imem_req = 1'b1; imem_addr = AW'(40 + k); imem_rready = 1'b1;
            settle();
            n_checks++; if (dmem_gnt !== 1'b0) $display("FAIL stall_gnt%0d: got %b expected 0", k, dmem_gnt); else n_pass++;
            n_checks++; if (dmem_rvalid !== 1'b1 || dmem_rdata !== WORD_10) $display("FAIL stall_hold%0d: got v %b d %h expected 1 %h", k, dmem_rvalid, dmem_rdata, WORD_10); else n_pass++;
            n_checks++; if (imem_gnt !== 1'b1) $display("FAIL stall_imem_gnt%0d: got %b expected 1", k, imem_gnt); else n_pass++;
            if (k > 0) begin
                n_checks++; if (imem_rvalid !== 1'b1 || imem_rdata !== imem_exp_q[0]) $display("FAIL stall_imem_rdata%0d: got %h expected %h", k, imem_rdata, imem_exp_q[0]); else n_pass++;
            end
            advance();
        end
        imem_req = 1'b0;
        dmem_rready = 1'b1;
        settle();
        n_checks++; if (dmem_rdata !== WORD_10) $display("FAIL stall_release_rdata: got %h expected %h", dmem_rdata, WORD_10); else n_pass++;
        n_checks++; if (dmem_gnt !== 1'b1) $display("FAIL stall_regrant: got %b expected 1", dmem_gnt); else n_pass++;
        advance();
        dmem_req = 1'b0;
        settle();
        n_checks++; if (dmem_rvalid !== 1'b1 || dmem_rdata !== WORD_20) $display("FAIL stall_next_rdata: got v %b d %h expected 1 %h", dmem_rvalid, dmem_rdata, WORD_20); else n_pass++;
        advance();
        idle_inputs();
        settle();
        advance();
    endtask

    task automatic test_streaming();
        int grants;
        int resps;
        grants = 0;
        resps = 0;
        for (int c = 0; c < 9; c++) begin
            imem_req = (c < 8); imem_addr = AW'(c); imem_rready = 1'b1;
            settle();
            if (imem_gnt === 1'b1) grants++;
            if (c > 0) begin
                resps++;
                n_checks++; if (imem_rvalid !== 1'b1 || imem_rdata !== shadow[c-1]) $display("FAIL stream_rsp%0d: got v %b d %h expected 1 %h", c - 1, imem_rvalid, imem_rdata, shadow[c-1]); else n_pass++;
            end
            advance();
        end
        n_checks++; if (grants != 8 || resps != 8) $display("FAIL stream_counts: got %0d grants %0d responses expected 8 8", grants, resps); else n_pass++;
        idle_inputs();
        settle();
        advance();
    endtask

    task automatic test_random();
        logic i_pend, d_pend;
        i_pend = 1'b0;
        d_pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!i_pend) begin
                imem_req  = ($urandom_range(0, 3) != 0);
                imem_addr = AW'($urandom_range(0, DEPTH - 1));
            end
            if (!d_pend) begin
                dmem_req   = ($urandom_range(0, 3) != 0);
                dmem_addr  = AW'($urandom_range(0, DEPTH - 1));
                dmem_strb  = ($urandom_range(0, 1) != 0) ? SW'($urandom) : '0;
                dmem_wdata = {$urandom, $urandom};
            end
            imem_rready = ($urandom_range(0, 3) != 0);
            dmem_rready = ($urandom_range(0, 3) != 0);
            settle();
            n_checks++; if ({imem_gnt, dmem_gnt} !== {exp_igrant, exp_dgrant}) $display("FAIL rand_gnt%0d: got %b expected %b", c, {imem_gnt, dmem_gnt}, {exp_igrant, exp_dgrant}); else n_pass++;
            n_checks++; if (sram_cen !== (exp_igrant | exp_dgrant)) $display("FAIL rand_cen%0d: got %b expected %b", c, sram_cen, exp_igrant | exp_dgrant); else n_pass++;
            n_checks++; if (sram_wstrb !== (exp_dgrant ? dmem_strb : SW'(0))) $display("FAIL rand_wstrb%0d: got %h expected %h", c, sram_wstrb, exp_dgrant ? dmem_strb : SW'(0)); else n_pass++;
            n_checks++; if ({imem_rvalid, dmem_rvalid} !== {imem_exp_q.size() != 0, dmem_exp_q.size() != 0}) $display("FAIL rand_rvalid%0d: got %b expected %b", c, {imem_rvalid, dmem_rvalid}, {imem_exp_q.size() != 0, dmem_exp_q.size() != 0}); else n_pass++;
            if (imem_exp_q.size() != 0) begin
                n_checks++; if (imem_rdata !== imem_exp_q[0]) $display("FAIL rand_irdata%0d: got %h expected %h", c, imem_rdata, imem_exp_q[0]); else n_pass++;
            end
            if (dmem_exp_q.size() != 0 && !dmem_wr_q[0]) begin
                n_checks++; if (dmem_rdata !== dmem_exp_q[0]) $display("FAIL rand_drdata%0d: got %h expected %h", c, dmem_rdata, dmem_exp_q[0]); else n_pass++;
            end
            i_pend = imem_req && !exp_igrant;
            d_pend = dmem_req && !exp_dgrant;
            advance();
        end
        idle_inputs();
        repeat (2) begin
            settle();
            advance();
        end
    endtask

    task automatic test_reset_mid();
        dmem_req = 1'b1; dmem_addr = AW'(5); dmem_rready = 1'b0;
        settle();
        advance();
        dmem_req = 1'b0;
        imem_req = 1'b1; imem_addr = AW'(6); imem_rready = 1'b1;
        settle();
        advance();
        n_checks++; if ({imem_rvalid, dmem_rvalid} !== 2'b11) $display("FAIL midrst_setup: got %b expected 11", {imem_rvalid, dmem_rvalid}); else n_pass++;
        imem_rready = 1'b0;
        dmem_req = 1'b1; imem_req = 1'b1; dmem_rready = 1'b1;
        #1;
        g_reset = 1'b1;
        #1;
        n_checks++; if ({imem_rvalid, dmem_rvalid} !== 2'b00) $display("FAIL midrst_rvalid: got %b expected 00", {imem_rvalid, dmem_rvalid}); else n_pass++;
        n_checks++; if ({imem_gnt, dmem_gnt, sram_cen} !== 3'b000) $display("FAIL midrst_gnt: got %b expected 000", {imem_gnt, dmem_gnt, sram_cen}); else n_pass++;
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        idle_inputs();
        model_clear();
        for (int k = 0; k < 3; k++) begin
            settle();
            n_checks++; if ({imem_rvalid, dmem_rvalid} !== 2'b00) $display("FAIL midrst_after%0d: got %b expected 00", k, {imem_rvalid, dmem_rvalid}); else n_pass++;
            advance();
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        n_checks = 0;
        n_pass = 0;
        model_clear();
        test_reset();
        preload();
        test_single_read();
        test_contention();
        test_stall();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
